uart_transmitter: RTL and testbench

Serial UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first, line idles high. It accepts one byte per valid/ready handshake and serialises it onto `tx` at `clk_per_bit` clocks per bit. It is the transmit-side counterpart of the team's `uart_receiver`, uses the same bit-timing parameter and the same 8N1 frame format, and drives the same serial link.

---
 rtl/uart_transmitter.sv | 116 +++++++++++
 tb/tb_uart_transmitter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first, idle-high line.
// Supports back-to-back frames by accepting the next byte in the final stop-bit cycle.
module uart_transmitter #(
    parameter int clk_per_bit = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(clk_per_bit - 1);
    localparam logic [15:0] CNT_DONE = 16'(clk_per_bit - 2);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        bit_end;
    logic        accept;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign cnt_d    = bit_end ? 16'd0 : cnt_q + 16'd1;
    assign tx_ready = (state_q == IDLE) || ((state_q == STOP_BIT) && bit_end);
    assign accept   = tx_valid && tx_ready;

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (accept) begin
                        shift_q <= d_in;
                        state_q <= START_BIT;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START_BIT: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q   <= DATA_BITS;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA_BITS: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP_BIT;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                STOP_BIT: begin
                    cnt_q <= cnt_d;
                    // Registered pulse lands exactly on the last stop-bit cycle.
                    if (cnt_q == CNT_DONE) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        if (accept) begin
                            shift_q <= d_in;
                            state_q <= START_BIT;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 16'd0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: two instances (4 and 217 clocks per bit),
// per-cycle line logging and a bench-side mid-bit sampling receiver.
module tb_uart_transmitter;

    logic       clk;
    logic       rst4, rst217;
    logic [7:0] din4, din217;
    logic       valid4, valid217;
    logic       ready4, ready217;
    logic       tx4, tx217;
    logic       busy4, busy217;
    logic       done4, done217;

    int errors;
    int checks;

    logic tx_log   [1:100];
    logic busy_log [1:100];
    logic done_log [1:100];

    uart_transmitter #(.clk_per_bit(4)) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .d_in     (din4),
        .tx_valid (valid4),
        .tx_ready (ready4),
        .tx       (tx4),
        .tx_busy  (busy4),
        .tx_done  (done4)
    );

    uart_transmitter #(.clk_per_bit(217)) dut217 (
        .clk      (clk),
        .rst      (rst217),
        .d_in     (din217),
        .tx_valid (valid217),
        .tx_ready (ready217),
        .tx       (tx217),
        .tx_busy  (busy217),
        .tx_done  (done217)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    // Accept `first` on the next rising edge, then log ncyc cycles (cycle 1 = first start-bit cycle).
    task automatic run_frame(input logic [7:0] first, input logic [7:0] after,
                             input int drop_at, input int pulse_at, input int ncyc);
        @(negedge clk);
        valid4 = 1'b1;
        din4   = first;
        @(posedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            tx_log[i]   = tx4;
            busy_log[i] = busy4;
            done_log[i] = done4;
            if (i == 1) din4 = after;
            if (i == drop_at) valid4 = 1'b0;
            if (i == pulse_at) begin
                valid4 = 1'b1;
                din4   = 8'h11;
            end
            if (pulse_at > 0 && i == pulse_at + 2) valid4 = 1'b0;
        end
    endtask

    task automatic check_frames(input string tag, input int nframes, input logic [7:0] b0,
                                input logic [7:0] b1, input int ncyc);
        int mism, dcnt, bcnt, dfirst, dlast, f;
        logic [9:0] fr;
        logic [9:0] word;
        logic e;
        mism = 0; dcnt = 0; bcnt = 0; dfirst = -1; dlast = -1;
        for (int i = 1; i <= ncyc; i++) begin
            f = (i - 1) / 40;
            if (f < nframes) begin
                fr = {1'b1, (f == 0) ? b0 : b1, 1'b0};
                e  = fr[((i - 1) % 40) / 4];
            end else begin
                e = 1'b1;
            end
            if (tx_log[i] !== e) mism++;
            if (busy_log[i] === 1'b1) bcnt++;
            if (done_log[i] === 1'b1) begin
                dcnt++;
                if (dfirst < 0) dfirst = i;
                dlast = i;
            end
        end
        for (int j = 0; j < 10; j++) word[j] = tx_log[4 * j + 2];
        check({tag, "_word"}, 32'(word), 32'({1'b1, b0, 1'b0}));
        check({tag, "_tx_mismatch_cycles"}, 32'(mism), 32'd0);
        check({tag, "_done_count"}, 32'(dcnt), 32'(nframes));
        check({tag, "_done_first_cycle"}, 32'(dfirst), 32'd40);
        check({tag, "_done_last_cycle"}, 32'(dlast), 32'(40 * nframes));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(40 * nframes));
        check({tag, "_busy_after"}, 32'(busy_log[40 * nframes + 1]), 32'd0);
    endtask

    initial begin
        int bcnt, dcnt, dpos, first_low;
        logic [9:0] rx;
        errors = 0;
        checks = 0;
        rst4 = 1'b0; rst217 = 1'b0;
        valid4 = 1'b0; valid217 = 1'b0;
        din4 = 8'h00; din217 = 8'h00;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx4), 32'd1);
            check("rst_busy", 32'(busy4), 32'd0);
            check("rst_done", 32'(done4), 32'd0);
        end
        rst4 = 1'b1; rst217 = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(ready4), 32'd1);
        check("rel_tx", 32'(tx4), 32'd1);
        check("rel_ready217", 32'(ready217), 32'd1);

        // Single byte 0xA5; d_in changes after accept must not matter.
        run_frame(8'hA5, 8'h3C, 1, 0, 45);
        check_frames("single_a5", 1, 8'hA5, 8'h00, 45);

        // Back-to-back 0x00 then 0xFF with valid held high.
        run_frame(8'h00, 8'hFF, 41, 0, 85);
        check_frames("b2b", 2, 8'h00, 8'hFF, 85);
        check("b2b_second_start", 32'(tx_log[41]), 32'd0);
        check("b2b_last_stop_of_first", 32'(tx_log[40]), 32'd1);

        // Request during DATA_BITS is ignored.
        run_frame(8'h5A, 8'h5A, 1, 15, 90);
        check_frames("ignored", 1, 8'h5A, 8'h00, 90);

        // Mid-frame reset during data bit 3 (cycles 17..20).
        run_frame(8'hA5, 8'hA5, 1, 0, 18);
        check("pre_rst_bit3_tx", 32'(tx4), 32'd0);
        rst4 = 1'b0;
        #1;
        check("abort_tx", 32'(tx4), 32'd1);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        @(negedge clk);
        check("abort_done_hold", 32'(done4), 32'd0);
        rst4 = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready4), 32'd1);
        check("abort_tx_idle", 32'(tx4), 32'd1);
        run_frame(8'h81, 8'h81, 1, 0, 45);
        check_frames("after_abort_81", 1, 8'h81, 8'h00, 45);

        // Data-hold at 217 clocks per bit with mid-bit sampling receiver.
        @(negedge clk);
        valid217 = 1'b1;
        din217   = 8'h3C;
        @(posedge clk);
        bcnt = 0; dcnt = 0; dpos = -1; first_low = -1; rx = 10'h0;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                valid217 = 1'b0;
                din217   = 8'hC3;
            end
            if (tx217 === 1'b0 && first_low < 0) first_low = i;
            if (busy217 === 1'b1) bcnt++;
            if (done217 === 1'b1) begin
                dcnt++;
                dpos = i;
            end
            if (((i - 1) % 217) == 108 && ((i - 1) / 217) < 10) rx[(i - 1) / 217] = tx217;
        end
        check("hold217_first_low", 32'(first_low), 32'd1);
        check("hold217_frame", 32'(rx), 32'({1'b1, 8'h3C, 1'b0}));
        check("hold217_busy_cycles", 32'(bcnt), 32'd2170);
        check("hold217_done_count", 32'(dcnt), 32'd1);
        check("hold217_done_cycle", 32'(dpos), 32'd2170);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
